// File: rtl/risc16_pkg.sv
// Shared RiSC-16 definitions: opcodes, field widths and the decoded bundle
// handed from decode to execute.
package risc16_pkg;

    localparam int unsigned XLEN     = 16;
    localparam int unsigned REG_W    = 3;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned IMM7_W   = 7;
    localparam int unsigned LUI_W    = 10;
    localparam int unsigned LUI_SH   = 6;
    localparam int unsigned NUM_REGS = 8;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_ADDI = 3'd1;
    localparam logic [OP_W-1:0] OP_NAND = 3'd2;
    localparam logic [OP_W-1:0] OP_LUI  = 3'd3;
    localparam logic [OP_W-1:0] OP_SW   = 3'd4;
    localparam logic [OP_W-1:0] OP_LW   = 3'd5;
    localparam logic [OP_W-1:0] OP_BEQ  = 3'd6;
    localparam logic [OP_W-1:0] OP_JALR = 3'd7;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] tgt;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
    } decoded_t;

endpackage

// File: rtl/risc16_scoreboard.sv
// Busy bits for r1..r7 tracking writes still in flight. r0 is never busy.
// The query reports a register busy only if it is not being retired by the
// writeback in the same cycle.
module risc16_scoreboard
    import risc16_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_wb_en,
    input  logic [REG_W-1:0] clr_wb_addr,
    input  logic             clr_fl_en,
    input  logic [REG_W-1:0] clr_fl_addr,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_addr,
    input  logic [REG_W-1:0] q_addr0,
    input  logic [REG_W-1:0] q_addr1,
    input  logic [REG_W-1:0] q_addr2,
    output logic             q_busy0,
    output logic             q_busy1,
    output logic             q_busy2
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Next busy vector: writeback clear, flush clear, then set (set wins).
    always_comb begin
        busy_d = busy_q;
        if (clr_wb_en) busy_d[clr_wb_addr] = 1'b0;
        if (clr_fl_en) busy_d[clr_fl_addr] = 1'b0;
        if (set_en)    busy_d[set_addr]    = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Busy register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign q_busy0 = busy_q[q_addr0] & ~(clr_wb_en & (clr_wb_addr == q_addr0));
    assign q_busy1 = busy_q[q_addr1] & ~(clr_wb_en & (clr_wb_addr == q_addr1));
    assign q_busy2 = busy_q[q_addr2] & ~(clr_wb_en & (clr_wb_addr == q_addr2));

endmodule

// File: rtl/risc16_decode.sv
// RiSC-16 decode/issue stage: field split, register-file read with
// writeback bypass, RAW/WAW hazard blocking and a registered handshaked
// bundle towards execute.
module risc16_decode
    import risc16_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_pc,
    output logic [REG_W-1:0]  src1,
    output logic [REG_W-1:0]  src2,
    input  logic [DATA_W-1:0] src1_val,
    input  logic [DATA_W-1:0] src2_val,
    input  logic              wb_we,
    input  logic [REG_W-1:0]  wb_tgt,
    input  logic [DATA_W-1:0] wb_val,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [REG_W-1:0]  out_tgt,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_pc
);

    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  reg_a;
    logic [REG_W-1:0]  reg_b;
    logic [REG_W-1:0]  reg_c;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic              busy1;
    logic              busy2;
    logic              busy_d;
    logic              hazard;
    logic              adv;
    logic              accept;
    decoded_t          bundle_q;
    decoded_t          bundle_d;

    assign op    = in_instr[15:13];
    assign reg_a = in_instr[12:10];
    assign reg_b = in_instr[9:7];
    assign reg_c = in_instr[REG_W-1:0];

    // Source/destination selection by opcode; unused sources read r0.
    always_comb begin
        src1 = reg_b;
        src2 = '0;
        dest = reg_a;
        case (op)
            OP_ADD, OP_NAND: src2 = reg_c;
            OP_SW, OP_BEQ: begin
                src2 = reg_a;
                dest = '0;
            end
            OP_LUI: src1 = '0;
            default: ;
        endcase
    end

    // Immediate: LUI places its 10 bits at the top, everything else sign-extends imm7.
    always_comb begin
        if (op == OP_LUI)
            imm = {in_instr[LUI_W-1:0], {LUI_SH{1'b0}}};
        else
            imm = {{(DATA_W-IMM7_W){in_instr[IMM7_W-1]}}, in_instr[IMM7_W-1:0]};
    end

    // Operand fetch: r0 reads zero, same-cycle writeback bypasses the file.
    always_comb begin
        if (src1 == '0)                     opnd_a = '0;
        else if (wb_we && (wb_tgt == src1)) opnd_a = wb_val;
        else                                opnd_a = src1_val;
        if (src2 == '0)                     opnd_b = '0;
        else if (wb_we && (wb_tgt == src2)) opnd_b = wb_val;
        else                                opnd_b = src2_val;
    end

    risc16_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .clr_wb_en   (wb_we),
        .clr_wb_addr (wb_tgt),
        .clr_fl_en   (flush & out_valid),
        .clr_fl_addr (bundle_q.tgt),
        .set_en      (accept),
        .set_addr    (dest),
        .q_addr0     (src1),
        .q_addr1     (src2),
        .q_addr2     (dest),
        .q_busy0     (busy1),
        .q_busy1     (busy2),
        .q_busy2     (busy_d)
    );

    assign hazard   = busy1 | busy2 | busy_d;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & ~hazard & ~flush & ~rst;
    assign accept   = in_valid & in_ready;

    // Assemble the bundle that loads on the next advancing edge.
    always_comb begin
        bundle_d     = bundle_q;
        bundle_d.op  = op;
        bundle_d.tgt = dest;
        bundle_d.a   = opnd_a;
        bundle_d.b   = opnd_b;
        bundle_d.imm = imm;
        bundle_d.pc  = in_pc;
    end

    // Output stage: flush kills the held bundle even while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            bundle_q  <= '0;
        end else begin
            if (flush)    out_valid <= 1'b0;
            else if (adv) out_valid <= accept;
            if (adv) bundle_q <= bundle_d;
        end
    end

    assign out_op  = bundle_q.op;
    assign out_tgt = bundle_q.tgt;
    assign out_a   = bundle_q.a;
    assign out_b   = bundle_q.b;
    assign out_imm = bundle_q.imm;
    assign out_pc  = bundle_q.pc;

endmodule

// File: tb/tb_risc16_decode.sv
// Self-checking bench for risc16_decode: directed scenarios plus a
// randomized stream checked against a behavioural pipeline model.
module tb_risc16_decode;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_instr;
    logic [15:0]       in_pc;
    logic [2:0]        src1;
    logic [2:0]        src2;
    logic [15:0]       src1_val;
    logic [15:0]       src2_val;
    logic              wb_we;
    logic [2:0]        wb_tgt;
    logic [15:0]       wb_val;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_op;
    logic [2:0]        out_tgt;
    logic [15:0]       out_a;
    logic [15:0]       out_b;
    logic [15:0]       out_imm;
    logic [15:0]       out_pc;

    logic [15:0]       rf [8];
    int                errors = 0;
    int                checks = 0;

    always #5 clk = ~clk;

    risc16_decode #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .src1(src1), .src2(src2),
        .src1_val(src1_val), .src2_val(src2_val), .wb_we(wb_we),
        .wb_tgt(wb_tgt), .wb_val(wb_val), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_tgt(out_tgt), .out_a(out_a), .out_b(out_b),
        .out_imm(out_imm), .out_pc(out_pc)
    );

    // Register file stand-in: fixed contents on reset, written by writeback.
    always @(posedge clk) begin
        if (rst) begin
            rf[0] <= 16'd0;  rf[1] <= 16'd5;  rf[2] <= 16'd7;  rf[3] <= 16'd3;
            rf[4] <= 16'd9;  rf[5] <= 16'd11; rf[6] <= 16'd13; rf[7] <= 16'd15;
        end else if (wb_we && wb_tgt != 3'd0) begin
            rf[wb_tgt] <= wb_val;
        end
    end

    assign src1_val = rf[src1];
    assign src2_val = rf[src2];

    function automatic logic [15:0] rrr(input logic [2:0] op, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [2:0] rc);
        return {op, ra, rb, 4'b0000, rc};
    endfunction

    function automatic logic [15:0] rri(input logic [2:0] op, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [6:0] i7);
        return {op, ra, rb, i7};
    endfunction

    function automatic logic [15:0] ri(input logic [2:0] op, input logic [2:0] ra,
                                       input logic [9:0] i10);
        return {op, ra, i10};
    endfunction

    // Reference instruction semantics: which registers are read and written.
    function automatic void ref_fields(input logic [15:0] i, output logic [2:0] s1,
                                       output logic [2:0] s2, output logic [2:0] d,
                                       output logic [15:0] imm);
        logic [2:0] ra;
        logic [2:0] rb;
        logic [2:0] rc;
        ra = i[12:10];
        rb = i[9:7];
        rc = i[2:0];
        imm = {{9{i[6]}}, i[6:0]};
        case (i[15:13])
            3'd0, 3'd2: begin s1 = rb; s2 = rc; d = ra; end          // ADD, NAND
            3'd1, 3'd5, 3'd7: begin s1 = rb; s2 = 3'd0; d = ra; end  // ADDI, LW, JALR
            3'd4, 3'd6: begin s1 = rb; s2 = ra; d = 3'd0; end        // SW, BEQ
            default: begin                                           // LUI
                s1 = 3'd0; s2 = 3'd0; d = ra;
                imm = i[9:0] * 16'd64;
            end
        endcase
    endfunction

    function automatic logic still_busy(input logic [7:0] pend, input logic [2:0] r,
                                        input logic we, input logic [2:0] t);
        return (r != 3'd0) && pend[r] && !(we && t == r);
    endfunction

    function automatic logic [15:0] ref_val(input logic [2:0] s, input logic we,
                                            input logic [2:0] t, input logic [15:0] v,
                                            input logic [15:0] fileval);
        if (s == 3'd0) return 16'd0;
        if (we && t == s) return v;
        return fileval;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_instr = '0; in_pc = '0; wb_we = 1'b0;
        wb_tgt = '0; wb_val = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_instr = '0; in_pc = '0; wb_we = 1'b0;
        wb_tgt = '0; wb_val = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++;
        if ({out_valid, out_op, out_tgt, out_a, out_b, out_imm, out_pc} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b op=%0d tgt=%0d a=%h b=%h imm=%h pc=%h expected all 0",
                     out_valid, out_op, out_tgt, out_a, out_b, out_imm, out_pc);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_raw_bypass();
        do_reset();
        in_valid = 1'b1; in_instr = rrr(3'd0, 3'd3, 3'd1, 3'd2); in_pc = 16'h0100;
        #1;
        checks++;
        if ({src1, src2, in_ready} !== {3'd1, 3'd2, 1'b1}) begin
            errors++; $display("FAIL add_issue: got src1=%0d src2=%0d rdy=%b expected 1 2 1", src1, src2, in_ready);
        end
        tick();
        in_instr = rri(3'd1, 3'd4, 3'd3, 7'h7F); in_pc = 16'h0101;
        #1;
        checks++;
        if ({out_valid, out_op, out_tgt, out_a, out_b, out_pc} !== {1'b1, 3'd0, 3'd3, 16'd5, 16'd7, 16'h0100}) begin
            errors++;
            $display("FAIL add_bundle: got v=%b op=%0d tgt=%0d a=%0d b=%0d pc=%h expected 1 0 3 5 7 0100",
                     out_valid, out_op, out_tgt, out_a, out_b, out_pc);
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_block: got %b expected 0", in_ready); end
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            errors++; $display("FAIL raw_block2: got v=%b rdy=%b expected 0 0", out_valid, in_ready);
        end
        wb_we = 1'b1; wb_tgt = 3'd3; wb_val = 16'd12;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_release: got %b expected 1", in_ready); end
        tick();
        wb_we = 1'b0; in_valid = 1'b0;
        checks++;
        if ({out_valid, out_op, out_tgt, out_a, out_b, out_imm} !== {1'b1, 3'd1, 3'd4, 16'd12, 16'd0, 16'hFFFF}) begin
            errors++;
            $display("FAIL addi_bypass: got v=%b op=%0d tgt=%0d a=%0d b=%0d imm=%h expected 1 1 4 12 0 ffff",
                     out_valid, out_op, out_tgt, out_a, out_b, out_imm);
        end
    endtask

    task automatic test_lui_waw();
        do_reset();
        in_valid = 1'b1; in_instr = ri(3'd3, 3'd2, 10'h3FF);
        #1;
        checks++;
        if ({src1, src2, in_ready} !== {3'd0, 3'd0, 1'b1}) begin
            errors++; $display("FAIL lui1_issue: got src1=%0d src2=%0d rdy=%b expected 0 0 1", src1, src2, in_ready);
        end
        tick();
        in_instr = ri(3'd3, 3'd2, 10'h001);
        #1;
        checks++;
        if ({out_valid, out_tgt, out_imm, out_a} !== {1'b1, 3'd2, 16'hFFC0, 16'd0}) begin
            errors++; $display("FAIL lui1_bundle: got v=%b tgt=%0d imm=%h a=%h expected 1 2 ffc0 0",
                               out_valid, out_tgt, out_imm, out_a);
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_block: got %b expected 0", in_ready); end
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_block2: got %b expected 0", in_ready); end
        wb_we = 1'b1; wb_tgt = 3'd2; wb_val = 16'hFFC0;
        #1;
        tick();
        wb_we = 1'b0; in_valid = 1'b0;
        checks++;
        if ({out_valid, out_tgt, out_imm} !== {1'b1, 3'd2, 16'h0040}) begin
            errors++; $display("FAIL lui2_bundle: got v=%b tgt=%0d imm=%h expected 1 2 0040", out_valid, out_tgt, out_imm);
        end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = rrr(3'd0, 3'd1, 3'd2, 3'd3); in_pc = 16'h0200;
        tick();
        in_instr = rrr(3'd2, 3'd5, 3'd6, 3'd7); in_pc = 16'h0201;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({in_ready, out_valid, out_op, out_tgt, out_a, out_b, out_pc} !==
                {1'b0, 1'b1, 3'd0, 3'd1, 16'd7, 16'd3, 16'h0200}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got rdy=%b v=%b op=%0d tgt=%0d a=%0d b=%0d pc=%h expected 0 1 0 1 7 3 0200",
                         i, in_ready, out_valid, out_op, out_tgt, out_a, out_b, out_pc);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_op, out_tgt, out_a, out_b, out_pc} !== {1'b1, 3'd2, 3'd5, 16'd13, 16'd15, 16'h0201}) begin
            errors++;
            $display("FAIL stall_next: got v=%b op=%0d tgt=%0d a=%0d b=%0d pc=%h expected 1 2 5 13 15 0201",
                     out_valid, out_op, out_tgt, out_a, out_b, out_pc);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_midstall();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = rrr(3'd0, 3'd4, 3'd1, 3'd2);
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, out_tgt, out_a, out_b} !== '0) begin
            errors++; $display("FAIL midstall_reset: got rdy=%b v=%b tgt=%0d a=%h b=%h expected 0 0 0 0 0",
                               in_ready, out_valid, out_tgt, out_a, out_b);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = rrr(3'd0, 3'd1, 3'd4, 3'd4);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midstall_busy_cleared: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = rri(3'd5, 3'd5, 3'd1, 7'd2);
        tick();
        in_instr = rrr(3'd0, 3'd1, 3'd5, 3'd0);
        #1;
        checks++;
        if ({out_valid, out_tgt, in_ready} !== {1'b1, 3'd5, 1'b0}) begin
            errors++; $display("FAIL flush_pre: got v=%b tgt=%0d rdy=%b expected 1 5 0", out_valid, out_tgt, in_ready);
        end
        in_instr = rrr(3'd0, 3'd6, 3'd1, 3'd2);
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_no_accept: got %b expected 0", in_ready); end
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill: got %b expected 0", out_valid); end
        out_ready = 1'b1;
        in_instr = rrr(3'd0, 3'd1, 3'd5, 3'd0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_release: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_tgt, out_a, out_b} !== {1'b1, 3'd1, 16'd11, 16'd0}) begin
            errors++; $display("FAIL flush_after: got v=%b tgt=%0d a=%0d b=%0d expected 1 1 11 0",
                               out_valid, out_tgt, out_a, out_b);
        end
    endtask

    task automatic test_r0();
        do_reset();
        in_valid = 1'b1; in_instr = rri(3'd4, 3'd0, 3'd0, 7'd3);
        #1;
        checks++;
        if ({src1, src2, in_ready} !== {3'd0, 3'd0, 1'b1}) begin
            errors++; $display("FAIL sw_r0_issue: got src1=%0d src2=%0d rdy=%b expected 0 0 1", src1, src2, in_ready);
        end
        tick();
        in_instr = rrr(3'd0, 3'd0, 3'd1, 3'd2);
        #1;
        checks++;
        if ({out_valid, out_op, out_tgt, out_a, out_b, out_imm, in_ready} !==
            {1'b1, 3'd4, 3'd0, 16'd0, 16'd0, 16'd3, 1'b1}) begin
            errors++; $display("FAIL sw_r0_bundle: got v=%b op=%0d tgt=%0d a=%h b=%h imm=%h rdy=%b expected 1 4 0 0 0 0003 1",
                               out_valid, out_op, out_tgt, out_a, out_b, out_imm, in_ready);
        end
        tick();
        in_instr = rrr(3'd0, 3'd3, 3'd0, 3'd0);
        #1;
        checks++;
        if ({out_valid, out_tgt, out_a, out_b, in_ready} !== {1'b1, 3'd0, 16'd5, 16'd7, 1'b1}) begin
            errors++; $display("FAIL add_r0_bundle: got v=%b tgt=%0d a=%0d b=%0d rdy=%b expected 1 0 5 7 1",
                               out_valid, out_tgt, out_a, out_b, in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0]  pend;
        logic        mv;
        logic [2:0]  m_op;
        logic [2:0]  m_tgt;
        logic [15:0] m_a;
        logic [15:0] m_b;
        logic [15:0] m_imm;
        logic [15:0] m_pc;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [2:0]  d;
        logic [15:0] imm;
        logic        adv;
        logic        exp_rdy;
        logic        acc;
        do_reset();
        pend = '0; mv = 1'b0;
        m_op = '0; m_tgt = '0; m_a = '0; m_b = '0; m_imm = '0; m_pc = '0;
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = 16'($urandom);
            in_pc     = 16'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            wb_we     = ($urandom_range(0, 2) == 0);
            wb_val    = 16'($urandom);
            wb_tgt    = 3'($urandom_range(1, 7));
            for (int k = 0; k < 7; k++)
                if (!pend[wb_tgt]) wb_tgt = (wb_tgt == 3'd7) ? 3'd1 : wb_tgt + 3'd1;
            #1;
            ref_fields(in_instr, s1, s2, d, imm);
            adv = !mv || out_ready;
            exp_rdy = adv && !flush &&
                      !still_busy(pend, s1, wb_we, wb_tgt) &&
                      !still_busy(pend, s2, wb_we, wb_tgt) &&
                      !still_busy(pend, d, wb_we, wb_tgt);
            acc = in_valid && exp_rdy;
            checks++;
            if ({src1, src2, in_ready} !== {s1, s2, exp_rdy}) begin
                errors++; $display("FAIL rand_issue[%0d]: got src1=%0d src2=%0d rdy=%b expected %0d %0d %b",
                                   n, src1, src2, in_ready, s1, s2, exp_rdy);
            end
            if (acc) begin
                m_op  = in_instr[15:13];
                m_tgt = d;
                m_a   = ref_val(s1, wb_we, wb_tgt, wb_val, rf[s1]);
                m_b   = ref_val(s2, wb_we, wb_tgt, wb_val, rf[s2]);
                m_imm = imm;
                m_pc  = in_pc;
            end
            if (wb_we) pend[wb_tgt] = 1'b0;
            if (flush && mv) pend[m_tgt] = 1'b0;
            if (acc && d != 3'd0) pend[d] = 1'b1;
            if (flush) mv = 1'b0;
            else if (adv) mv = acc;
            tick();
            checks++;
            if (out_valid !== mv) begin
                errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, out_valid, mv);
            end
            if (mv) begin
                checks++;
                if ({out_op, out_tgt, out_a, out_b, out_imm, out_pc} !== {m_op, m_tgt, m_a, m_b, m_imm, m_pc}) begin
                    errors++;
                    $display("FAIL rand_bundle[%0d]: got op=%0d tgt=%0d a=%h b=%h imm=%h pc=%h expected %0d %0d %h %h %h %h",
                             n, out_op, out_tgt, out_a, out_b, out_imm, out_pc,
                             m_op, m_tgt, m_a, m_b, m_imm, m_pc);
                end
            end
        end
        in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_raw_bypass();
        test_lui_waw();
        test_stall();
        test_reset_midstall();
        test_flush();
        test_r0();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
